// File: rtl/text_console_writer.sv
// text_console_writer: turns a stream of ASCII bytes into text RAM writes.
// It tracks the cursor and handles line wrap, LF, CR, BS and form-feed clear.
// Scrolling is circular: entering a row blanks it in place, and no rows move.
module text_console_writer #(
   parameter int COLS   = 80,
   parameter int ROWS   = 60,
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        char_in,
   input  logic              char_valid,
   output logic              char_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [6:0]        cursor_col,
   output logic [5:0]        cursor_row,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLR_LINE = 2'd1,
      CLR_ALL  = 2'd2
   } state_t;

   localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
   localparam logic [5:0]        LAST_ROW  = 6'(ROWS - 1);
   localparam logic [ADDR_W-1:0] LINE_END  = ADDR_W'(COLS - 1);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
   localparam logic [7:0]        BLANK     = 8'h20;

   state_t              state, state_next;
   logic [ADDR_W-1:0]   clr_cnt, clr_cnt_next;
   logic [6:0]          col_next;
   logic [5:0]          row_next;
   logic                wr_en_next;
   logic [ADDR_W-1:0]   wr_addr_next;
   logic [7:0]          wr_data_next;
   logic                accept;

   // Linear text RAM address of a cell, computed at full address width.
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0]        row,
                                                    input logic [ADDR_W-1:0] offs);
      cell_addr = ADDR_W'(row) * ADDR_W'(COLS) + offs;
   endfunction

   // Printable ASCII range, space through tilde.
   function automatic logic is_printable(input logic [7:0] code);
      is_printable = (code >= 8'h20) && (code <= 8'h7E);
   endfunction

   // Row below the given one, wrapping from the bottom row back to the top.
   function automatic logic [5:0] next_row(input logic [5:0] row);
      next_row = (row == LAST_ROW) ? 6'd0 : row + 6'd1;
   endfunction

   assign char_ready = (state == IDLE);
   assign busy       = (state != IDLE);
   assign accept     = char_valid && char_ready;

   // Next-state logic: byte decode while idle, one blank-cell write per cycle while clearing.
   always_comb begin
      state_next   = state;
      clr_cnt_next = clr_cnt;
      col_next     = cursor_col;
      row_next     = cursor_row;
      wr_en_next   = 1'b0;
      wr_addr_next = wr_addr;
      wr_data_next = wr_data;

      case (state)
         IDLE: begin
            if (accept) begin
               if (is_printable(char_in)) begin
                  wr_en_next   = 1'b1;
                  wr_addr_next = cell_addr(cursor_row, ADDR_W'(cursor_col));
                  wr_data_next = char_in;
                  if (cursor_col != LAST_COL) begin
                     col_next = cursor_col + 7'd1;
                  end else begin
                     col_next     = 7'd0;
                     row_next     = next_row(cursor_row);
                     clr_cnt_next = '0;
                     state_next   = CLR_LINE;
                  end
               end else begin
                  case (char_in)
                     8'h0A: begin
                        col_next     = 7'd0;
                        row_next     = next_row(cursor_row);
                        clr_cnt_next = '0;
                        state_next   = CLR_LINE;
                     end
                     8'h0D: begin
                        col_next = 7'd0;
                     end
                     8'h08: begin
                        if (cursor_col != 7'd0) begin
                           col_next     = cursor_col - 7'd1;
                           wr_en_next   = 1'b1;
                           wr_addr_next = cell_addr(cursor_row, ADDR_W'(cursor_col - 7'd1));
                           wr_data_next = BLANK;
                        end
                     end
                     8'h0C: begin
                        col_next     = 7'd0;
                        row_next     = 6'd0;
                        clr_cnt_next = '0;
                        state_next   = CLR_ALL;
                     end
                     default: begin
                        // Control codes without a defined action are swallowed.
                     end
                  endcase
               end
            end
         end

         CLR_LINE: begin
            // The cursor row already points at the row being entered.
            wr_en_next   = 1'b1;
            wr_addr_next = cell_addr(cursor_row, clr_cnt);
            wr_data_next = BLANK;
            if (clr_cnt == LINE_END) begin
               clr_cnt_next = '0;
               state_next   = IDLE;
            end else begin
               clr_cnt_next = clr_cnt + 1'b1;
            end
         end

         CLR_ALL: begin
            wr_en_next   = 1'b1;
            wr_addr_next = clr_cnt;
            wr_data_next = BLANK;
            if (clr_cnt == LAST_CELL) begin
               clr_cnt_next = '0;
               state_next   = IDLE;
            end else begin
               clr_cnt_next = clr_cnt + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, cursor, clear counter and the registered RAM write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         clr_cnt    <= '0;
         cursor_col <= 7'd0;
         cursor_row <= 6'd0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 8'h00;
      end else begin
         state      <= state_next;
         clr_cnt    <= clr_cnt_next;
         cursor_col <= col_next;
         cursor_row <= row_next;
         wr_en      <= wr_en_next;
         wr_addr    <= wr_addr_next;
         wr_data    <= wr_data_next;
      end
   end

endmodule

// File: tb/tb_text_console_writer.sv
// Testbench for text_console_writer: a byte-level console model feeds a write
// scoreboard, and a monitor pops one expected write for every DUT write strobe.
module tb_text_console_writer;
   localparam int COLS   = 80;
   localparam int ROWS   = 60;
   localparam int ADDR_W = 13;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        char_in = 8'h00;
   logic              char_valid = 1'b0;
   logic              char_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [6:0]        cursor_col;
   logic [5:0]        cursor_row;
   logic              busy;

   text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
      .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; int data; } wr_t;
   wr_t exp_q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_wr_cyc = -1;
   int prev_wr_cyc = -1;

   // Console model state
   int m_row = 0;
   int m_col = 0;
   bit m_busy = 0;
   int m_wait = 0;

   always @(posedge clk) cyc = cyc + 1;

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (wr_en === 1'b1) begin
         prev_wr_cyc = last_wr_cyc;
         last_wr_cyc = cyc;
         tests = tests + 1;
         if (exp_q.size() == 0) begin
            fails = fails + 1;
            $display("FAIL unexpected_write: got addr=%0d data=%02h, expected no write",
                     wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            if (int'(wr_addr) != e.addr || int'(wr_data) != e.data) begin
               fails = fails + 1;
               $display("FAIL write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                        wr_addr, wr_data, e.addr, e.data);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests = tests + 1;
      if (act != exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void push_wr(input int addr, input int data);
      wr_t e;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endfunction

   function automatic void model_newline();
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      for (int i = 0; i < COLS; i++) push_wr(m_row * COLS + i, 32);
      m_busy = 1;
      m_wait = COLS;
   endfunction

   // Console behaviour for one accepted byte, straight from the character rules.
   function automatic void model_byte(input int b);
      m_busy = 0;
      m_wait = 0;
      if (b >= 32 && b <= 126) begin
         push_wr(m_row * COLS + m_col, b);
         if (m_col == COLS - 1) model_newline();
         else m_col = m_col + 1;
      end else if (b == 10) begin
         model_newline();
      end else if (b == 13) begin
         m_col = 0;
      end else if (b == 8) begin
         if (m_col > 0) begin
            m_col = m_col - 1;
            push_wr(m_row * COLS + m_col, 32);
         end
      end else if (b == 12) begin
         m_row = 0;
         m_col = 0;
         for (int i = 0; i < COLS * ROWS; i++) push_wr(i, 32);
         m_busy = 1;
         m_wait = COLS * ROWS;
      end
   endfunction

   // Offer a byte (held until ready), then check the cursor after the accept edge.
   task automatic send(input logic [7:0] b, output int waited);
      @(negedge clk);
      char_in = b;
      char_valid = 1'b1;
      waited = 0;
      while (char_ready !== 1'b1 && waited < 10000) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 10000) begin
         fails = fails + 1;
         $display("FAIL ready_timeout: got char_ready=%b after %0d cycles, expected 1", char_ready, waited);
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $fatal(1, "ready timeout");
      end
      model_byte(int'(b));
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      check("cursor_col", int'(cursor_col), m_col);
      check("cursor_row", int'(cursor_row), m_row);
      check("busy_after_accept", int'(busy), int'(m_busy));
   endtask

   task automatic send_printable();
      int n;
      send(8'($urandom_range(32, 126)), n);
   endtask

   initial begin
      int n;
      int r;
      logic [7:0] others [7];
      others = '{8'h00, 8'h07, 8'h09, 8'h1B, 8'h7F, 8'h80, 8'hFF};

      // Reset held two cycles
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_char_ready", int'(char_ready), 1);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_cursor_col", int'(cursor_col), 0);
      check("rst_cursor_row", int'(cursor_row), 0);
      check("rst_busy", int'(busy), 0);
      reset = 1'b0;

      // Reset ten cycles into a full clear
      send(8'h0C, n);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      m_row = 0;
      m_col = 0;
      check("midclr_char_ready", int'(char_ready), 1);
      check("midclr_busy", int'(busy), 0);
      check("midclr_wr_en", int'(wr_en), 0);
      check("midclr_cursor_col", int'(cursor_col), 0);
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("post_reset_wr_en", int'(wr_en), 0);

      // 'A' then 'B' back to back
      send(8'h41, n);
      send(8'h42, n);
      @(negedge clk);
      #1;
      check("ab_consecutive_writes", last_wr_cyc - prev_wr_cyc, 1);
      check("ab_cursor_col", int'(cursor_col), 2);

      // Fill to column 79, then wrap with 'Z'
      repeat (77) send_printable();
      check("pre_wrap_col", int'(cursor_col), 79);
      send(8'h5A, n);
      send(8'h0D, n);
      check("wrap_clear_wait", n, COLS);

      // Walk to (59,3), LF wraps to row 0, then CR at col 5
      repeat (58) send(8'h0A, n);
      repeat (3) send_printable();
      check("pre_lf_row", int'(cursor_row), 59);
      send(8'h0A, n);
      repeat (5) send_printable();
      send(8'h0D, n);

      // Backspace cases and an ignored control code
      send(8'h0A, n);
      send(8'h0A, n);
      repeat (5) send_printable();
      send(8'h08, n);
      send(8'h0D, n);
      send(8'h08, n);
      send(8'h07, n);

      // Randomised byte mix
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 75)      send_printable();
         else if (r < 83) send(8'h0A, n);
         else if (r < 88) send(8'h0D, n);
         else if (r < 95) send(8'h08, n);
         else             send(others[$urandom_range(0, 6)], n);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      end

      // Full clear with 'Q' held until the clear finishes
      send(8'h0C, n);
      send(8'h51, n);
      check("ff_hold_wait", n, COLS * ROWS);

      // Drain outstanding writes
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
